// File: rtl/arb_grant_pipe.sv
// Grant capture pipe: encodes a one-hot arbiter grant, buffers {client, payload}
// in a 2-entry FIFO and back-pressures the arbiter with a registered stall.
module arb_grant_pipe #(
    parameter int CLIENTS = 32,
    parameter int DATA_W  = 16,
    localparam int IDX_W  = $clog2(CLIENTS)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [CLIENTS-1:0]         grant,
    input  logic [CLIENTS*DATA_W-1:0]  req_data,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [IDX_W-1:0]           out_client,
    output logic [DATA_W-1:0]          out_data,
    output logic                       stall,
    output logic                       onehot_err,
    output logic [7:0]                 drop_count
);

    logic [IDX_W-1:0]  mem_client [2];
    logic [DATA_W-1:0] mem_data   [2];
    logic              rd_ptr;
    logic              wr_ptr;
    logic [1:0]        count;
    logic [1:0]        count_nxt;
    logic [IDX_W-1:0]  enc;
    logic              onehot;
    logic              multi;
    logic              push;
    logic              pop;

    always_comb begin
        enc = '0;
        for (int i = 0; i < CLIENTS; i++) begin
            if (grant[i]) enc = enc | IDX_W'(i);
        end
    end

    // x & (x-1) clears the lowest set bit; zero result means at most one bit set
    assign onehot = (grant != '0) && ((grant & (grant - CLIENTS'(1))) == '0);
    assign multi  = (grant != '0) && !onehot;
    assign push   = onehot && !stall;
    assign pop    = out_valid && out_ready;

    always_comb begin
        count_nxt = count;
        unique case ({push, pop})
            2'b10:   count_nxt = count + 2'd1;
            2'b01:   count_nxt = count - 2'd1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_client[0] <= '0;
            mem_client[1] <= '0;
            mem_data[0]   <= '0;
            mem_data[1]   <= '0;
            rd_ptr        <= 1'b0;
            wr_ptr        <= 1'b0;
            count         <= 2'd0;
            stall         <= 1'b0;
            onehot_err    <= 1'b0;
            drop_count    <= 8'd0;
        end else begin
            if (push) begin
                mem_client[wr_ptr] <= enc;
                mem_data[wr_ptr]   <= req_data[enc*DATA_W +: DATA_W];
                wr_ptr             <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count      <= count_nxt;
            stall      <= (count_nxt == 2'd2);
            onehot_err <= multi && !stall;
            if (multi && !stall && drop_count != 8'hFF)
                drop_count <= drop_count + 8'd1;
        end
    end

    assign out_valid  = (count != 2'd0);
    assign out_client = out_valid ? mem_client[rd_ptr] : '0;
    assign out_data   = out_valid ? mem_data[rd_ptr] : '0;

endmodule

// File: tb/tb_arb_grant_pipe.sv
// Directed bench for arb_grant_pipe with a queue scoreboard and
// a per-cycle output monitor.
module tb_arb_grant_pipe;

    localparam int CLIENTS = 32;
    localparam int DATA_W  = 16;
    localparam int IDX_W   = 5;

    logic                      clock = 1'b0;
    logic                      reset = 1'b1;
    logic [CLIENTS-1:0]        grant = '0;
    logic [CLIENTS*DATA_W-1:0] req_data = '0;
    logic                      out_ready = 1'b0;
    logic                      out_valid;
    logic [IDX_W-1:0]          out_client;
    logic [DATA_W-1:0]         out_data;
    logic                      stall;
    logic                      onehot_err;
    logic [7:0]                drop_count;

    arb_grant_pipe #(.CLIENTS(CLIENTS), .DATA_W(DATA_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .grant      (grant),
        .req_data   (req_data),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_client (out_client),
        .out_data   (out_data),
        .stall      (stall),
        .onehot_err (onehot_err),
        .drop_count (drop_count)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [IDX_W-1:0]  c;
        logic [DATA_W-1:0] d;
    } ent_t;

    ent_t       q[$];
    logic       exp_err  = 1'b0;
    logic [7:0] exp_drop = 8'd0;
    int         n_chk    = 0;
    int         n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int bits_set(input logic [CLIENTS-1:0] g);
        int n = 0;
        for (int i = 0; i < CLIENTS; i++) n += int'(g[i]);
        return n;
    endfunction

    function automatic int first_set(input logic [CLIENTS-1:0] g);
        for (int i = 0; i < CLIENTS; i++) if (g[i]) return i;
        return 0;
    endfunction

    // Reference model, advanced on each active edge
    always @(posedge clock) begin
        if (!reset) begin
            ent_t e;
            bit   full;
            bit   do_pop;
            bit   do_push;
            int   k;
            full    = (q.size() == 2);
            do_pop  = (q.size() != 0) && out_ready;
            do_push = (bits_set(grant) == 1) && !full;
            exp_err = !full && (bits_set(grant) > 1);
            if (exp_err && exp_drop != 8'hFF) exp_drop = exp_drop + 8'd1;
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                k   = first_set(grant);
                e.c = IDX_W'(k);
                e.d = req_data[k*DATA_W +: DATA_W];
                q.push_back(e);
            end
        end
    end

    // Output monitor, sampled away from the active edge
    always @(negedge clock) begin
        if (!reset) begin
            check("valid", 32'(out_valid), 32'(q.size() != 0));
            check("stall", 32'(stall), 32'(q.size() == 2));
            check("onehot_err", 32'(onehot_err), 32'(exp_err));
            check("drop_count", 32'(drop_count), 32'(exp_drop));
            if (q.size() != 0) begin
                check("client", 32'(out_client), 32'(q[0].c));
                check("data", 32'(out_data), 32'(q[0].d));
            end else begin
                check("idle_data", 32'(out_data), 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_slot(input int c, input logic [DATA_W-1:0] v);
        req_data[c*DATA_W +: DATA_W] = v;
    endtask

    task automatic grant_to(input int c);
        grant = '0;
        grant[c] = 1'b1;
    endtask

    logic [DATA_W-1:0] held;

    initial begin
        for (int i = 0; i < CLIENTS; i++) set_slot(i, DATA_W'(16'hA000 + i));
        repeat (2) @(posedge clock);
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_client", 32'(out_client), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_err", 32'(onehot_err), 32'd0);
        check("rst_drop", 32'(drop_count), 32'd0);
        reset = 1'b0;

        // single grant, latency 1
        set_slot(4, 16'hBEEF);
        grant_to(4);
        out_ready = 1'b1;
        tick();
        grant = '0;
        #2;
        check("s1_valid", 32'(out_valid), 32'd1);
        check("s1_client", 32'(out_client), 32'd4);
        check("s1_data", 32'(out_data), 32'hBEEF);
        tick();
        #2;
        check("s1_drain", 32'(out_valid), 32'd0);

        // fill, stall, ignored grant, drain
        out_ready = 1'b0;
        grant_to(1);
        tick();
        grant_to(2);
        tick();
        grant_to(3);
        tick();
        grant = '0;
        #2;
        check("s2_stall", 32'(stall), 32'd1);
        check("s2_head", 32'(out_client), 32'd1);
        out_ready = 1'b1;
        tick();
        #2;
        check("s2_unstall", 32'(stall), 32'd0);
        check("s2_head2", 32'(out_client), 32'd2);
        tick();
        tick();

        // illegal grant and saturation
        grant = 32'h0000_0003;
        tick();
        grant = '0;
        #2;
        check("s3_valid", 32'(out_valid), 32'd0);
        check("s3_err", 32'(onehot_err), 32'd1);
        check("s3_drop", 32'(drop_count), 32'd1);
        tick();
        #2;
        check("s3_err_pulse", 32'(onehot_err), 32'd0);
        for (int i = 0; i < 300; i++) begin
            grant = '0;
            grant[i % 31] = 1'b1;
            grant[(i % 31) + 1] = 1'b1;
            tick();
        end
        grant = '0;
        tick();
        #2;
        check("s3_sat", 32'(drop_count), 32'd255);

        // simultaneous push and pop at occupancy 1
        out_ready = 1'b0;
        grant_to(7);
        tick();
        grant_to(9);
        out_ready = 1'b1;
        tick();
        grant = '0;
        out_ready = 1'b0;
        #2;
        check("s4_client", 32'(out_client), 32'd9);
        check("s4_valid", 32'(out_valid), 32'd1);
        check("s4_stall", 32'(stall), 32'd0);
        out_ready = 1'b1;
        tick();
        tick();

        // hold under back-pressure while payloads change
        out_ready = 1'b0;
        set_slot(5, 16'h5A5A);
        grant_to(5);
        tick();
        grant = '0;
        held = 16'h5A5A;
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < CLIENTS; j++) set_slot(j, DATA_W'($urandom));
            tick();
            check("s5_client", 32'(out_client), 32'd5);
            check("s5_data", 32'(out_data), 32'(held));
        end
        out_ready = 1'b1;
        tick();
        tick();

        // asynchronous reset while full
        out_ready = 1'b0;
        grant_to(1);
        tick();
        grant_to(2);
        tick();
        grant = '0;
        #2;
        check("s6_full", 32'(stall), 32'd1);
        reset = 1'b1;
        q.delete();
        exp_err  = 1'b0;
        exp_drop = 8'd0;
        #1;
        check("s6_valid", 32'(out_valid), 32'd0);
        check("s6_stall", 32'(stall), 32'd0);
        check("s6_data", 32'(out_data), 32'd0);
        check("s6_drop", 32'(drop_count), 32'd0);
        tick();
        reset = 1'b0;
        set_slot(0, 16'h1234);
        grant_to(0);
        out_ready = 1'b1;
        tick();
        grant = '0;
        #2;
        check("s6_valid2", 32'(out_valid), 32'd1);
        check("s6_client", 32'(out_client), 32'd0);
        check("s6_payload", 32'(out_data), 32'h1234);
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
